// File: rtl/traffic_pkg.sv
// Shared lamp encodings and controller state type.
package traffic_pkg;

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;
   localparam logic [2:0] LAMP_OFF    = 3'b000;

   typedef enum logic [3:0] {
      AR_NS,
      NS_G,
      NS_Y,
      AR_X,
      PED,
      EW_G,
      EW_Y,
      FLASH_ON,
      FLASH_OFF
   } state_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable saturating down-counter; expired is registered alongside the count.
module phase_timer #(
   parameter int unsigned CNT_W   = 16,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] cnt;

   // Load on phase entry, otherwise count down and stick at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= RST_VAL;
         expired <= (RST_VAL == '0);
      end else if (load) begin
         cnt     <= load_val;
         expired <= (load_val == '0);
      end else if (cnt != '0) begin
         cnt     <= cnt - CNT_W'(1);
         expired <= (cnt == CNT_W'(1));
      end
   end

endmodule

// File: rtl/traffic_light_ctrl_param.sv
// Sensor-actuated two-way traffic light with pedestrian phase and night flash.
module traffic_light_ctrl_param
   import traffic_pkg::*;
#(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned NS_MIN_T   = 8,
   parameter int unsigned EW_GREEN_T = 6,
   parameter int unsigned YELLOW_T   = 3,
   parameter int unsigned ALLRED_T   = 2,
   parameter int unsigned WALK_T     = 5,
   parameter int unsigned FLASH_T    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ew_car,
   input  logic       ped_btn,
   input  logic       flash_en,
   output logic [2:0] NS,
   output logic [2:0] EW,
   output logic       walk,
   output logic       ew_pend,
   output logic       ped_pend
);

   state_t           state, state_nxt;
   logic             expired;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             ew_pend_nxt, ped_pend_nxt;
   logic             in_flash;

   // Timer reload value (duration-1) for the phase being entered.
   function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
      case (s)
         NS_G:                dur_m1 = CNT_W'(NS_MIN_T - 1);
         NS_Y, EW_Y:          dur_m1 = CNT_W'(YELLOW_T - 1);
         PED:                 dur_m1 = CNT_W'(WALK_T - 1);
         EW_G:                dur_m1 = CNT_W'(EW_GREEN_T - 1);
         FLASH_ON, FLASH_OFF: dur_m1 = CNT_W'(FLASH_T - 1);
         default:             dur_m1 = CNT_W'(ALLRED_T - 1);
      endcase
   endfunction

   phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (CNT_W'(ALLRED_T - 1))
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .expired  (expired)
   );

   // State and demand latch registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= AR_NS;
         ew_pend  <= 1'b0;
         ped_pend <= 1'b0;
      end else begin
         state    <= state_nxt;
         ew_pend  <= ew_pend_nxt;
         ped_pend <= ped_pend_nxt;
      end
   end

   // Next-state, timer reload, demand latches and lamp decode.
   always_comb begin
      state_nxt    = state;
      NS           = LAMP_RED;
      EW           = LAMP_RED;
      walk         = 1'b0;
      in_flash     = (state == FLASH_ON) || (state == FLASH_OFF);

      case (state)
         AR_NS: if (expired) state_nxt = flash_en ? FLASH_ON : NS_G;
         NS_G: begin
            NS = LAMP_GREEN;
            if (expired && (ew_pend || ped_pend)) state_nxt = NS_Y;
         end
         NS_Y: begin
            NS = LAMP_YELLOW;
            if (expired) state_nxt = AR_X;
         end
         AR_X: if (expired) state_nxt = ped_pend ? PED : (ew_pend ? EW_G : AR_NS);
         PED: begin
            walk = 1'b1;
            if (expired) state_nxt = ew_pend ? EW_G : AR_NS;
         end
         EW_G: begin
            EW = LAMP_GREEN;
            if (expired) state_nxt = EW_Y;
         end
         EW_Y: begin
            EW = LAMP_YELLOW;
            if (expired) state_nxt = AR_NS;
         end
         FLASH_ON: begin
            NS = LAMP_YELLOW;
            if (expired) state_nxt = FLASH_OFF;
         end
         FLASH_OFF: begin
            NS = LAMP_OFF;
            EW = LAMP_OFF;
            if (expired) state_nxt = flash_en ? FLASH_ON : AR_NS;
         end
         default: state_nxt = AR_NS;
      endcase

      load     = (state_nxt != state);
      load_val = dur_m1(state_nxt);

      // Set on demand outside flash; serving the phase (or entering flash) clears.
      ew_pend_nxt  = ew_pend  | (ew_car  & ~in_flash);
      ped_pend_nxt = ped_pend | (ped_btn & ~in_flash);
      if ((state_nxt == EW_G) && (state != EW_G)) ew_pend_nxt = 1'b0;
      if ((state_nxt == PED) && (state != PED)) ped_pend_nxt = 1'b0;
      if ((state_nxt == FLASH_ON) && (state == AR_NS)) begin
         ew_pend_nxt  = 1'b0;
         ped_pend_nxt = 1'b0;
      end
   end

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Directed bench for traffic_light_ctrl_param with short phase durations.
module tb_traffic_light_ctrl_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       ew_car;
   logic       ped_btn;
   logic       flash_en;
   logic [2:0] NS;
   logic [2:0] EW;
   logic       walk;
   logic       ew_pend;
   logic       ped_pend;

   int checks = 0;
   int errors = 0;
   logic inv_en = 1'b0;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] O = 3'b000;

   traffic_light_ctrl_param #(
      .CNT_W      (16),
      .NS_MIN_T   (4),
      .EW_GREEN_T (3),
      .YELLOW_T   (2),
      .ALLRED_T   (1),
      .WALK_T     (3),
      .FLASH_T    (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ew_car   (ew_car),
      .ped_btn  (ped_btn),
      .flash_en (flash_en),
      .NS       (NS),
      .EW       (EW),
      .walk     (walk),
      .ew_pend  (ew_pend),
      .ped_pend (ped_pend)
   );

   always #5 clk = ~clk;

   // Safety invariant sampled on every falling edge once reset has been applied.
   always @(negedge clk) begin
      if (inv_en) begin
         checks++;
         assert (((NS === R) || (EW === R) || ((NS === O) && (EW === O))) &&
                 (!walk || ((NS === R) && (EW === R))))
         else begin
            errors++;
            $error("FAIL safety observed NS=%b EW=%b walk=%b expected no conflicting lamps",
                   NS, EW, walk);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [2:0] ens, input logic [2:0] eew,
                      input logic ewk, input logic eep, input logic epp);
      logic [8:0] obs, exp;
      obs = {NS, EW, walk, ew_pend, ped_pend};
      exp = {ens, eew, ewk, eep, epp};
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed {NS,EW,walk,ewp,pedp}=%b expected %b", tag, obs, exp);
      end
   endtask

   // n consecutive cycles with identical expected outputs.
   task automatic seq(input string tag, input int n, input logic [2:0] ens,
                      input logic [2:0] eew, input logic ewk, input logic eep,
                      input logic epp);
      for (int i = 0; i < n; i++) begin
         step();
         chk(tag, ens, eew, ewk, eep, epp);
      end
   endtask

   initial begin
      rst = 1'b1; ew_car = 1'b0; ped_btn = 1'b0; flash_en = 1'b0;

      // Reset, then rest in NS green with no demand.
      step();
      chk("reset", R, R, 0, 0, 0);
      inv_en = 1'b1;
      rst = 1'b0;
      seq("ns_rest", 50, G, R, 0, 0, 0);

      // EW car pulse while resting in green.
      ew_car = 1'b1;
      step(); chk("ew_latch", G, R, 0, 1, 0);
      ew_car = 1'b0;
      seq("ew_nsy", 2, Y, R, 0, 1, 0);
      seq("ew_arx", 1, R, R, 0, 1, 0);
      seq("ew_g",   3, R, G, 0, 0, 0);
      seq("ew_y",   2, R, Y, 0, 0, 0);
      seq("ew_arns",1, R, R, 0, 0, 0);
      seq("ew_back",1, G, R, 0, 0, 0);

      // Pedestrian press inside minimum green does not shorten it.
      rst = 1'b1;
      step(); chk("reset2", R, R, 0, 0, 0);
      rst = 1'b0;
      seq("ped_nsg12", 2, G, R, 0, 0, 0);
      ped_btn = 1'b1;
      step(); chk("ped_nsg3", G, R, 0, 0, 1);
      ped_btn = 1'b0;
      step(); chk("ped_nsg4", G, R, 0, 0, 1);
      seq("ped_nsy",  2, Y, R, 0, 0, 1);
      seq("ped_arx",  1, R, R, 0, 0, 1);
      seq("ped_walk", 3, R, R, 1, 0, 0);
      seq("ped_arns", 1, R, R, 0, 0, 0);
      seq("ped_back", 1, G, R, 0, 0, 0);

      // Both demands together: PED served before EW.
      ew_car = 1'b1; ped_btn = 1'b1;
      step(); chk("both_latch", G, R, 0, 1, 1);
      ew_car = 1'b0; ped_btn = 1'b0;
      seq("both_nsg",  2, G, R, 0, 1, 1);
      seq("both_nsy",  2, Y, R, 0, 1, 1);
      seq("both_arx",  1, R, R, 0, 1, 1);
      seq("both_walk", 3, R, R, 1, 1, 0);
      seq("both_ewg",  3, R, G, 0, 0, 0);
      seq("both_ewy",  2, R, Y, 0, 0, 0);
      seq("both_arns", 1, R, R, 0, 0, 0);
      seq("both_back", 1, G, R, 0, 0, 0);

      // Flash requested mid-cycle; entered only from AR_NS.
      flash_en = 1'b1; ew_car = 1'b1;
      step(); chk("fl_nsg2", G, R, 0, 1, 0);
      ew_car = 1'b0;
      seq("fl_nsg",  2, G, R, 0, 1, 0);
      seq("fl_nsy",  2, Y, R, 0, 1, 0);
      seq("fl_arx",  1, R, R, 0, 1, 0);
      seq("fl_ewg",  3, R, G, 0, 0, 0);
      seq("fl_ewy",  2, R, Y, 0, 0, 0);
      seq("fl_arns", 1, R, R, 0, 0, 0);
      seq("fl_on1",  2, Y, R, 0, 0, 0);
      seq("fl_off1", 2, O, O, 0, 0, 0);
      ew_car = 1'b1; ped_btn = 1'b1;
      step(); chk("fl_frozen", Y, R, 0, 0, 0);
      ew_car = 1'b0; ped_btn = 1'b0; flash_en = 1'b0;
      step(); chk("fl_on2b", Y, R, 0, 0, 0);
      seq("fl_off2",  2, O, O, 0, 0, 0);
      seq("fl_exit",  1, R, R, 0, 0, 0);
      seq("fl_back",  1, G, R, 0, 0, 0);

      // Clear-wins on EW_G entry, then reset mid EW_G.
      ew_car = 1'b1;
      step(); chk("rs_latch", G, R, 0, 1, 0);
      seq("rs_nsg",   2, G, R, 0, 1, 0);
      seq("rs_nsy",   2, Y, R, 0, 1, 0);
      seq("rs_arx",   1, R, R, 0, 1, 0);
      seq("rs_clrwin",1, R, G, 0, 0, 0);
      ped_btn = 1'b1;
      step(); chk("rs_relatch", R, G, 0, 1, 1);
      rst = 1'b1; ew_car = 1'b0; ped_btn = 1'b0;
      step(); chk("rs_reset", R, R, 0, 0, 0);
      rst = 1'b0;
      seq("rs_back", 1, G, R, 0, 0, 0);

      @(negedge clk);
      inv_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
